// File: rtl/imem_load_if.sv
// Loader stream, instruction-memory write port and boot status of imem_load_controller.
//   slave  modport: used by the controller (takes load_*, drives everything else)
//   master modport: used by the loader / system side
// Signals:
//   load_start, load_valid, load_data[15:0], load_last  loader -> controller
//   load_ready                                          controller -> loader
//   imem_write_enable, imem_write_addr[31:0],
//   imem_write_data[15:0]                               instruction memory write port
//   cpu_rst, running, word_count[N:0], overflow_err     boot status
interface imem_load_if #(
    parameter int unsigned N = 6
) ();
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        imem_write_enable;
    logic [31:0] imem_write_addr;
    logic [15:0] imem_write_data;
    logic        cpu_rst;
    logic        running;
    logic [N:0]  word_count;
    logic        overflow_err;

    modport master (
        output load_start, load_valid, load_data, load_last,
        input  load_ready, imem_write_enable, imem_write_addr, imem_write_data,
        input  cpu_rst, running, word_count, overflow_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        output load_ready, imem_write_enable, imem_write_addr, imem_write_data,
        output cpu_rst, running, word_count, overflow_err
    );
endinterface

// File: rtl/imem_load_controller.sv
// Program-load and boot sequencer for the instruction memory.
// Accepts 16-bit words from a valid/ready loader stream and writes them to consecutive
// instruction-memory addresses starting at BASE (the fetch entry address). The processor is
// held in reset while loading and for RST_CYCLES cycles after the last word, then released.
// Ports:
//   clk  system clock (posedge)
//   rst  asynchronous active-high reset
//   bus  imem_load_if slave: loader stream in, memory write port / cpu_rst / status out
module imem_load_controller #(
    parameter int unsigned N          = 6,
    parameter int unsigned BASE       = 32,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    imem_load_if.slave  bus
);
    localparam int unsigned CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [N-1:0]  PTR_BASE  = N'(BASE);
    localparam logic [N-1:0]  PTR_MAX   = '1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StBoot, StRun, StError} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  ptr_q;
    logic [N:0]    word_count_q;
    logic          overflow_q;
    logic          we_q;
    logic [N-1:0]  waddr_q;
    logic [15:0]   wdata_q;
    logic [CW-1:0] boot_cnt_q;

    logic load_ready;
    logic accept;
    logic start_load;

    // Next-state and handshake decode
    always_comb begin
        state_d    = state_q;
        load_ready = (state_q == StLoad);
        accept     = bus.load_valid & load_ready;
        // load_start is honoured everywhere except LOAD and BOOT
        start_load = bus.load_start &
                     ((state_q == StIdle) | (state_q == StRun) | (state_q == StError));
        unique case (state_q)
            StIdle, StRun, StError: begin
                if (start_load) state_d = StLoad;
            end
            StLoad: begin
                if (accept) begin
                    if (bus.load_last)        state_d = StBoot;
                    else if (ptr_q == PTR_MAX) state_d = StError;
                end
            end
            StBoot: begin
                if (boot_cnt_q == BOOT_LAST) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= PTR_BASE;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            boot_cnt_q   <= '0;
        end else begin
            // Write strobe is a registered copy of the accept, so exactly one cycle per word
            we_q <= accept;
            if (start_load) begin
                ptr_q        <= PTR_BASE;
                word_count_q <= '0;
                overflow_q   <= 1'b0;
            end else if (accept) begin
                waddr_q      <= ptr_q;
                wdata_q      <= bus.load_data;
                ptr_q        <= ptr_q + 1'b1;
                word_count_q <= word_count_q + 1'b1;
                if (!bus.load_last && (ptr_q == PTR_MAX)) overflow_q <= 1'b1;
            end
            // Counter is zero on BOOT entry and advances once per BOOT cycle
            if (state_q == StBoot) boot_cnt_q <= boot_cnt_q + 1'b1;
            else                   boot_cnt_q <= '0;
        end
    end

    assign bus.load_ready        = load_ready;
    assign bus.imem_write_enable = we_q;
    assign bus.imem_write_addr   = 32'(waddr_q);
    assign bus.imem_write_data   = wdata_q;
    assign bus.cpu_rst           = (state_q != StRun);
    assign bus.running           = (state_q == StRun);
    assign bus.word_count        = word_count_q;
    assign bus.overflow_err      = overflow_q;
endmodule

// File: tb/tb_imem_load_controller.sv
// Directed bench for imem_load_controller with hand-computed expectations.
module tb_imem_load_controller;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    imem_load_if #(.N(6)) bus ();

    imem_load_controller #(
        .N(6),
        .BASE(32),
        .RST_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic start, input logic valid, input logic [15:0] data,
                         input logic last);
        bus.load_start = start;
        bus.load_valid = valid;
        bus.load_data  = data;
        bus.load_last  = last;
    endtask

    task automatic check_write(input string tag, input logic we, input int addr,
                               input logic [15:0] data);
        check({tag, "_we"}, 32'(bus.imem_write_enable), 32'(we));
        if (we) begin
            check({tag, "_addr"}, bus.imem_write_addr, 32'(addr));
            check({tag, "_data"}, 32'(bus.imem_write_data), 32'(data));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        // Reset values
        check("rst_ready", 32'(bus.load_ready), 32'd0);
        check("rst_we", 32'(bus.imem_write_enable), 32'd0);
        check("rst_addr", bus.imem_write_addr, 32'd0);
        check("rst_data", 32'(bus.imem_write_data), 32'd0);
        check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_wc", 32'(bus.word_count), 32'd0);
        check("rst_ovf", 32'(bus.overflow_err), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_ready", 32'(bus.load_ready), 32'd0);

        // Three-word back-to-back load
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        step();
        check("t1_ready", 32'(bus.load_ready), 32'd1);
        check("t1_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        drive(1'b0, 1'b1, 16'h1111, 1'b0);
        step();
        check_write("t1_w0", 1'b1, 32, 16'h1111);
        drive(1'b0, 1'b1, 16'h2222, 1'b0);
        step();
        check_write("t1_w1", 1'b1, 33, 16'h2222);
        drive(1'b0, 1'b1, 16'h3333, 1'b1);
        step();
        check_write("t1_w2", 1'b1, 34, 16'h3333);
        check("t1_wc", 32'(bus.word_count), 32'd3);
        check("t1_boot_ready", 32'(bus.load_ready), 32'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check_write("t1_idle_we", 1'b0, 0, 16'h0);
        check("t1_boot_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("t1_boot_running", 32'(bus.running), 32'd0);
        step();
        check("t1_run_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        check("t1_run_running", 32'(bus.running), 32'd1);

        // Reload from RUN; word presented with load_start must not be accepted
        drive(1'b1, 1'b1, 16'hABCD, 1'b1);
        step();
        check("t2_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("t2_running", 32'(bus.running), 32'd0);
        check_write("t2_noacc", 1'b0, 0, 16'h0);
        check("t2_wc0", 32'(bus.word_count), 32'd0);
        drive(1'b0, 1'b1, 16'hABCD, 1'b1);
        step();
        check_write("t2_w0", 1'b1, 32, 16'hABCD);
        check("t2_wc", 32'(bus.word_count), 32'd1);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check("t2_boot", 32'(bus.running), 32'd0);
        step();
        check("t2_run", 32'(bus.running), 32'd1);

        // Gapped valid plus ignored load_start during LOAD
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        step();
        drive(1'b0, 1'b1, 16'hAAAA, 1'b0);
        step();
        check_write("t3_w0", 1'b1, 32, 16'hAAAA);
        drive(1'b1, 1'b0, 16'h5555, 1'b0);
        step();
        check_write("t3_gap", 1'b0, 0, 16'h0);
        check("t3_gap_wc", 32'(bus.word_count), 32'd1);
        check("t3_gap_ready", 32'(bus.load_ready), 32'd1);
        drive(1'b0, 1'b1, 16'hBBBB, 1'b1);
        step();
        check_write("t3_w1", 1'b1, 33, 16'hBBBB);
        check("t3_wc", 32'(bus.word_count), 32'd2);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check_write("t3_gap2", 1'b0, 0, 16'h0);
        step();
        check("t3_run", 32'(bus.running), 32'd1);

        // Exactly capacity: 32 words, last on word 32
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 16'(16'h1000 + i), (i == 31));
            step();
            check_write("t4_w", 1'b1, 32 + i, 16'(16'h1000 + i));
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        check("t4_wc", 32'(bus.word_count), 32'd32);
        check("t4_ovf", 32'(bus.overflow_err), 32'd0);
        step();
        step();
        check("t4_run", 32'(bus.running), 32'd1);
        check("t4_ovf_run", 32'(bus.overflow_err), 32'd0);

        // Overflow: no last within capacity
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 16'(16'h2000 + i), 1'b0);
            step();
            check_write("t5_w", 1'b1, 32 + i, 16'(16'h2000 + i));
        end
        check("t5_ovf", 32'(bus.overflow_err), 32'd1);
        check("t5_ready", 32'(bus.load_ready), 32'd0);
        check("t5_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        drive(1'b0, 1'b1, 16'h2020, 1'b1);
        step();
        check_write("t5_noacc", 1'b0, 0, 16'h0);
        check("t5_wc", 32'(bus.word_count), 32'd32);
        step();
        check("t5_ovf_held", 32'(bus.overflow_err), 32'd1);
        check("t5_running", 32'(bus.running), 32'd0);

        // Restart from ERROR, then reset mid-load after two words of five
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        step();
        check("t6_ovf_clr", 32'(bus.overflow_err), 32'd0);
        check("t6_ready", 32'(bus.load_ready), 32'd1);
        drive(1'b0, 1'b1, 16'h3000, 1'b0);
        step();
        drive(1'b0, 1'b1, 16'h3001, 1'b0);
        step();
        check_write("t6_w1", 1'b1, 33, 16'h3001);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_we", 32'(bus.imem_write_enable), 32'd0);
        check("t6_rst_addr", bus.imem_write_addr, 32'd0);
        check("t6_rst_data", 32'(bus.imem_write_data), 32'd0);
        check("t6_rst_wc", 32'(bus.word_count), 32'd0);
        check("t6_rst_ready", 32'(bus.load_ready), 32'd0);
        check("t6_rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        step();
        check("t6_re_wc", 32'(bus.word_count), 32'd0);
        drive(1'b0, 1'b1, 16'h4444, 1'b1);
        step();
        check_write("t6_re_w0", 1'b1, 32, 16'h4444);
        check("t6_re_wc1", 32'(bus.word_count), 32'd1);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        step();
        step();
        check("t6_run", 32'(bus.running), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
